axi_rd_arbiter: RTL and testbench

- Shares the single AXI read-address/read-data channel pair between the instruction-fetch and data-load SRAM-like requesters.
- Sits inside the SRAM-to-AXI bridge, between the IFU/EXEU request ports and the AXI AR/R pins.
- Provides fixed-priority arbitration with an anti-starvation override, per-ID outstanding-transaction tracking, read-after-write address blocking, and rid-based return routing.

---
 rtl/axi_rd_arbiter_pkg.sv | 14 +
 rtl/axi_rd_arbiter_os_counter.sv | 41 ++++
 rtl/axi_rd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and AR channel state encoding for the read arbiter.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

endpackage

// File: rtl/axi_rd_arbiter_os_counter.sv
// Outstanding-read counter for one AXI ID: saturating up/down with full flag.
// A decrement with nothing outstanding is dropped and reported on underflow_o.
module rd_os_counter #(
    parameter int MAX = 2,
    parameter int W   = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         underflow_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         dec_ok;

    assign dec_ok      = dec_i && (cnt_q != '0);
    assign underflow_o = dec_i && (cnt_q == '0);
    assign full_o      = (cnt_q >= W'(MAX));
    assign cnt_o       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_ok && !full_o) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_ok && !inc_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between instruction-fetch and data-load requesters:
// fixed data priority with inst anti-starvation, per-ID outstanding limits, RAW blocking.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        err_rid
);

    localparam int              ST_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);

    ar_state_e       state_q, state_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [3:0]      arid_q, arid_d;
    logic [2:0]      arsize_q, arsize_d;
    logic [ST_W-1:0] starve_q, starve_d;
    logic            err_q, err_d;
    logic            run_q;

    logic             raw_hit, data_elig, inst_elig;
    logic             grant_inst, grant_data;
    logic             inst_full, data_full, inst_uf, data_uf;
    logic [CNT_W-1:0] inst_cnt, data_cnt;
    logic             r_beat, rid_inst, rid_data, inst_dec, data_dec;

    // Grants wait for run_q so nothing is accepted while reset is asserted.
    assign raw_hit   = wr_busy && (((data_addr ^ wr_addr) >> 2) == 32'd0);
    assign data_elig = run_q && data_req && !data_full && !raw_hit;
    assign inst_elig = run_q && inst_req && !inst_full;

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        arsize_d   = arsize_q;
        starve_d   = starve_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state_q)
            AR_IDLE: begin
                if (data_elig && !(inst_elig && starve_q == STARVE_MAX)) begin
                    grant_data = 1'b1;
                    araddr_d   = data_addr;
                    arid_d     = ID_DATA;
                    arsize_d   = {1'b0, data_size};
                    state_d    = AR_HOLD;
                end else if (inst_elig) begin
                    grant_inst = 1'b1;
                    araddr_d   = inst_addr;
                    arid_d     = ID_INST;
                    arsize_d   = {1'b0, inst_size};
                    state_d    = AR_HOLD;
                end
            end
            AR_HOLD: begin
                if (arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase

        if (!inst_req || grant_inst) begin
            starve_d = '0;
        end else if (grant_data && inst_elig && starve_q != STARVE_MAX) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    assign r_beat   = rvalid && rready;
    assign rid_inst = (rid == ID_INST);
    assign rid_data = (rid == ID_DATA);
    assign inst_dec = r_beat && rlast && rid_inst;
    assign data_dec = r_beat && rlast && rid_data;

    // Beats for an ID with nothing outstanding (e.g. stale after reset) are swallowed.
    assign inst_data_ok = r_beat && rid_inst && (inst_cnt != '0);
    assign data_data_ok = r_beat && rid_data && (data_cnt != '0);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign err_d = err_q || (r_beat && !rid_inst && !rid_data) || inst_uf || data_uf;

    rd_os_counter #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_inst_cnt (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .inc_i      (grant_inst),
        .dec_i      (inst_dec),
        .cnt_o      (inst_cnt),
        .full_o     (inst_full),
        .underflow_o(inst_uf)
    );

    rd_os_counter #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_data_cnt (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .inc_i      (grant_data),
        .dec_i      (data_dec),
        .cnt_o      (data_cnt),
        .full_o     (data_full),
        .underflow_o(data_uf)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= AR_IDLE;
            araddr_q <= '0;
            arid_q   <= '0;
            arsize_q <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            arsize_q <= arsize_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            run_q    <= 1'b1;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign arvalid      = (state_q == AR_HOLD);
    assign araddr       = araddr_q;
    assign arid         = arid_q;
    assign arsize       = arsize_q;
    assign arlen        = LEN_SINGLE;
    assign arburst      = BURST_INCR;
    assign arlock       = 2'b00;
    assign arcache      = 4'b0000;
    assign rready       = run_q;
    assign err_rid      = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: AXI slave model, rdata scoreboard,
// grant-vector table and hand-written multi-cycle sequences.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, wr_busy;
    logic [31:0] inst_addr, data_addr, wr_addr;
    logic [1:0]  inst_size, data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic        arvalid, arready, rlast, rvalid, rready, err_rid;

    always #5 aclk = ~aclk;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_rid(err_rid)
    );

    typedef struct { logic [3:0] id; logic [31:0] addr; } ar_t;
    typedef struct { logic [3:0] id; logic [31:0] data; } beat_t;
    typedef struct {
        logic        inst_req, data_req, wr_busy;
        logic [31:0] inst_addr, data_addr, wr_addr;
        logic [1:0]  size;
        logic        exp_iok, exp_dok;
    } vec_t;

    ar_t         ar_q[$];
    beat_t       inj_q[$];
    logic [31:0] exp_inst_q[$], exp_data_q[$];
    int          grant_log[$];
    int          checks = 0, errors = 0;
    bit          auto_resp;
    int          n_inst_ok = 0, n_inst_dok = 0;
    logic [31:0] last_inst_rdata;

    logic        s_inst_ok, s_data_ok, s_arvalid, s_rready;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [2:0]  s_arsize;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h1c00_0040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic inject(input logic [3:0] id, input logic [31:0] d);
        beat_t b;
        b.id = id;
        b.data = d;
        inj_q.push_back(b);
    endtask

    // One clock: sample/score at negedge, then play the AXI slave just after posedge.
    task automatic tick();
        bit    taken;
        ar_t   a;
        beat_t b;
        @(negedge aclk);
        s_inst_ok = inst_addr_ok;
        s_data_ok = data_addr_ok;
        s_arvalid = arvalid;
        s_arid    = arid;
        s_araddr  = araddr;
        s_arsize  = arsize;
        s_rready  = rready;
        if (inst_addr_ok) begin
            exp_inst_q.push_back(rd_model(inst_addr));
            grant_log.push_back(0);
            n_inst_ok++;
        end
        if (data_addr_ok) begin
            exp_data_q.push_back(rd_model(data_addr));
            grant_log.push_back(1);
        end
        if (arvalid && arready) begin
            a.id = arid;
            a.addr = araddr;
            ar_q.push_back(a);
        end
        if (inst_data_ok) begin
            n_inst_dok++;
            last_inst_rdata = inst_rdata;
            if (exp_inst_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL inst_data_ok unexpected: rdata 0x%08h, none outstanding", inst_rdata);
            end else check("inst_rdata", inst_rdata, exp_inst_q.pop_front());
        end
        if (data_data_ok) begin
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_data_ok unexpected: rdata 0x%08h, none outstanding", data_rdata);
            end else check("data_rdata", data_rdata, exp_data_q.pop_front());
        end
        taken = rvalid && rready;
        @(posedge aclk);
        #1;
        if (taken) rvalid = 1'b0;
        if (!rvalid) begin
            if (inj_q.size() > 0) begin
                b = inj_q.pop_front();
                rvalid = 1'b1; rid = b.id; rdata = b.data; rlast = 1'b1;
            end else if (auto_resp && ar_q.size() > 0) begin
                a = ar_q.pop_front();
                rvalid = 1'b1; rid = a.id; rdata = rd_model(a.addr); rlast = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((ar_q.size() != 0 || exp_inst_q.size() != 0 || exp_data_q.size() != 0 ||
                rvalid || arvalid) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain timeout: inst pending %0d, data pending %0d, expected 0",
                     exp_inst_q.size(), exp_data_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   exp_pat[8];
        int   n, n0, dok0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1c00_0000, 32'h0000_1000, 32'h0000_0000, 2'd2, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h1c00_0000, 32'h0000_1000, 32'h0000_0000, 2'd2, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h1c00_0004, 32'h0000_1004, 32'h0000_0000, 2'd2, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h1c00_0010, 32'h0000_2006, 32'h0000_2004, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h1c00_0010, 32'h0000_2006, 32'h0000_2004, 2'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h1c00_0010, 32'h0000_2004, 32'h0000_2008, 2'd0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h1c00_0010, 32'h0000_2004, 32'h0000_2008, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h1c00_0020, 32'h0000_3000, 32'h0000_3004, 2'd2, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h1c00_0020, 32'h0000_2000, 32'h0000_2003, 2'd2, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 32'h1c00_0020, 32'h0000_2004, 32'h0000_2004, 2'd2, 1'b0, 1'b1};
        exp_pat = '{1, 1, 1, 0, 1, 1, 1, 0};

        aresetn = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; wr_busy = 1'b0;
        inst_addr = '0; data_addr = '0; wr_addr = '0; inst_size = 2'd2; data_size = 2'd2;
        arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b0;
        auto_resp = 1'b1;
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("reset arvalid", arvalid, 0);
        check("reset inst_addr_ok", inst_addr_ok, 0);
        check("reset data_addr_ok", data_addr_ok, 0);
        check("reset err_rid", err_rid, 0);
        check("reset araddr", araddr, 0);
        check("reset arid", arid, 0);
        check("reset arsize", arsize, 0);
        inst_req = 1'b0; data_req = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        tick();
        tick();
        check("post-reset rready", s_rready, 1);
        check("post-reset arvalid", s_arvalid, 0);

        // Grant-decision table, one request pulse per vector from an idle, empty arbiter.
        for (int i = 0; i < 10; i++) begin
            inst_req = vecs[i].inst_req; data_req = vecs[i].data_req; wr_busy = vecs[i].wr_busy;
            inst_addr = vecs[i].inst_addr; data_addr = vecs[i].data_addr; wr_addr = vecs[i].wr_addr;
            inst_size = vecs[i].size; data_size = vecs[i].size;
            tick();
            check($sformatf("vec%0d inst_addr_ok", i), s_inst_ok, vecs[i].exp_iok);
            check($sformatf("vec%0d data_addr_ok", i), s_data_ok, vecs[i].exp_dok);
            inst_req = 1'b0; data_req = 1'b0; wr_busy = 1'b0;
            tick();
            check($sformatf("vec%0d arvalid", i), s_arvalid, vecs[i].exp_iok | vecs[i].exp_dok);
            if (vecs[i].exp_iok || vecs[i].exp_dok) begin
                check($sformatf("vec%0d arid", i), s_arid, vecs[i].exp_dok ? 32'd1 : 32'd0);
                check($sformatf("vec%0d araddr", i), s_araddr,
                      vecs[i].exp_dok ? vecs[i].data_addr : vecs[i].inst_addr);
                check($sformatf("vec%0d arsize", i), s_arsize, {1'b0, vecs[i].size});
            end
            drain();
        end

        // Simultaneous requests: data first, inst on the next idle cycle.
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; data_req = 1'b1; data_addr = 32'h0000_1000;
        inst_size = 2'd2; data_size = 2'd2;
        tick();
        check("simul data_addr_ok", s_data_ok, 1);
        check("simul inst_addr_ok first", s_inst_ok, 0);
        data_req = 1'b0;
        tick();
        check("simul AR arvalid", s_arvalid, 1);
        check("simul AR arid", s_arid, 1);
        check("simul AR araddr", s_araddr, 32'h0000_1000);
        check("simul hold no grant", s_inst_ok, 0);
        tick();
        check("simul inst_addr_ok next", s_inst_ok, 1);
        inst_req = 1'b0;
        tick();
        check("simul inst arid", s_arid, 0);
        check("simul inst araddr", s_araddr, 32'h1c00_0000);
        check("arlen", arlen, 0);
        check("arburst", arburst, 2'b01);
        check("arlock", arlock, 0);
        check("arcache", arcache, 0);
        drain();

        // Anti-starvation: both held, data wins three times then inst is forced.
        grant_log.delete();
        inst_req = 1'b1; inst_addr = 32'h1c00_0100; data_req = 1'b1; data_addr = 32'h0000_4000;
        n = 0;
        while (grant_log.size() < 8 && n < 100) begin
            tick();
            n++;
        end
        inst_req = 1'b0; data_req = 1'b0;
        check("starve grant count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check($sformatf("starve grant%0d is_data", k), grant_log[k], exp_pat[k]);
        drain();

        // Read-after-write block on the same 32-bit word.
        inst_req = 1'b1; inst_addr = 32'h1c00_0200;
        data_req = 1'b1; data_addr = 32'h0000_2006; wr_busy = 1'b1; wr_addr = 32'h0000_2004;
        tick();
        check("raw inst granted", s_inst_ok, 1);
        check("raw data blocked", s_data_ok, 0);
        inst_req = 1'b0;
        tick();
        tick();
        check("raw data still blocked", s_data_ok, 0);
        wr_busy = 1'b0;
        tick();
        check("raw data after wr done", s_data_ok, 1);
        data_req = 1'b0;
        drain();

        // Outstanding limit: third inst request waits for a response.
        auto_resp = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c00_0040;
        n0 = n_inst_ok;
        repeat (10) tick();
        check("os limit accepted", n_inst_ok - n0, 2);
        auto_resp = 1'b1;
        dok0 = n_inst_dok;
        n = 0;
        while (n_inst_ok - n0 < 3 && n < 20) begin
            tick();
            n++;
        end
        inst_req = 1'b0;
        check("os third accepted", n_inst_ok - n0, 3);
        check("os response before third", n_inst_dok - dok0 >= 1, 1);
        check("os response rdata", last_inst_rdata, 32'hDEAD_BEEF);
        drain();

        // Unknown rid: consumed silently, sticky error.
        check("err_rid clean before", err_rid, 0);
        inject(4'd5, 32'h1234_5678);
        repeat (3) tick();
        check("err_rid after rid5", err_rid, 1);
        data_req = 1'b1; data_addr = 32'h0000_5000;
        tick();
        data_req = 1'b0;
        drain();
        check("err_rid sticky", err_rid, 1);

        // Async reset while holding an AR.
        auto_resp = 1'b0; arready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c00_0300;
        tick();
        check("hold inst_addr_ok", s_inst_ok, 1);
        inst_req = 1'b0;
        tick();
        check("hold arvalid", s_arvalid, 1);
        #3 aresetn = 1'b0;
        #1;
        check("async reset arvalid", arvalid, 0);
        check("async reset err_rid", err_rid, 0);
        exp_inst_q.delete(); exp_data_q.delete(); ar_q.delete(); inj_q.delete();
        rvalid = 1'b0; arready = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        inject(4'd0, 32'hCAFE_0000);
        repeat (3) tick();
        check("after reset arvalid idle", s_arvalid, 0);
        check("stale beat err_rid", err_rid, 1);
        inst_req = 1'b1; inst_addr = 32'h1c00_0400;
        n0 = n_inst_ok;
        repeat (10) tick();
        inst_req = 1'b0;
        check("after reset counter cleared", n_inst_ok - n0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
